// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: N-requester arbiter that can run in fixed-priority or
// round-robin mode. A grant is held until the downstream side acks it.
// All outputs are registered.
// Optional build macro: ARB_TIMEOUT_EN adds a forced release after TIMEOUT
// cycles without an ack, signalled by a one-cycle timeout pulse.
module rr_priority_arbiter #(
   parameter int N       = 8,
   parameter int IDXW    = $clog2(N),
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            mode,
   input  logic            ack,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] grant_idx,
   output logic            valid,
   output logic            timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    grant_q, win_grant;
   logic [IDXW-1:0] idx_q, ptr_q, ptr_d, ptr_inc, base;
   logic [IDXW-1:0] win_idx;
   logic            win_found;
   logic            force_rel;
   logic            release_now;
   logic            load;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;
   logic          timeout_q;

   assign force_rel = (state_q == GRANT) && !ack && (cnt_q == CW'(TIMEOUT - 1));

   // Hold-time counter: restarts on every new grant, counts un-acked GRANT cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= force_rel;
         if (load)
            cnt_q <= '0;
         else if (state_q == GRANT && !ack)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

   assign ptr_inc     = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + 1'b1;
   assign release_now = (state_q == GRANT) && (ack || force_rel);
   // Re-arbitration on a release already searches from the advanced pointer.
   assign base        = release_now ? ptr_inc : ptr_q;

   // Winner search: lowest index in fixed mode, first set bit from base in round-robin.
   always_comb begin
      int unsigned pos;
      win_found = 1'b0;
      win_idx   = '0;
      pos       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         if (mode) begin
            pos = int'(base) + k;
            if (pos >= N) pos = pos - N;
         end else begin
            pos = k;
         end
         if (!win_found && req[pos]) begin
            win_found = 1'b1;
            win_idx   = IDXW'(pos);
         end
      end
      win_grant          = '0;
      win_grant[win_idx] = 1'b1;
   end

   // Next-state and load decision for the grant registers.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               load    = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_d = ptr_inc;
               if (win_found) load = 1'b1;
               else           state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pointer and grant output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (load) begin
            idx_q   <= win_idx;
            grant_q <= win_grant;
         end else if (state_d == IDLE) begin
            idx_q   <= '0;
            grant_q <= '0;
         end
      end
   end

   assign grant     = grant_q;
   assign grant_idx = idx_q;
   assign valid     = (state_q == GRANT);

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter (N=8, TIMEOUT=4): a vector table
// followed by hand-written timeout sequences.
module tb_rr_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       mode;
   logic       ack;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       valid;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   rr_priority_arbiter #(.N(8), .IDXW(3), .TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mode      (mode),
      .ack       (ack),
      .grant     (grant),
      .grant_idx (grant_idx),
      .valid     (valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       mode;
      logic       ack;
      logic       ev;
      logic [7:0] eg;
      logic [2:0] ei;
      logic       et;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [7:0] q, input logic m, input logic a,
                      input logic ev, input logic [7:0] eg, input logic [2:0] ei);
      vec_t v;
      v.rst = r; v.req = q; v.mode = m; v.ack = a;
      v.ev = ev; v.eg = eg; v.ei = ei; v.et = 1'b0;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic [7:0] q, input logic m, input logic a);
      rst = r; req = q; mode = m; ack = a;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic ev, input logic [7:0] eg,
                        input logic [2:0] ei, input logic et);
      checks++;
      if ({valid, grant, grant_idx, timeout} !== {ev, eg, ei, et}) begin
         failures++;
         $display("FAIL %s: got valid=%b grant=%h idx=%0d timeout=%b, need valid=%b grant=%h idx=%0d timeout=%b",
                  name, valid, grant, grant_idx, timeout, ev, eg, ei, et);
      end
   endtask

   initial begin
      logic et_exp;
      drive(1'b1, 8'hFF, 1'b1, 1'b0);

      // Reset held two cycles with requests pending
      add(1, 8'hFF, 1, 0, 0, 8'h00, 0);
      add(1, 8'hFF, 1, 0, 0, 8'h00, 0);
      // First grant one cycle after reset release
      add(0, 8'hFF, 1, 0, 1, 8'h01, 0);
      // Round-robin, all requesting, ack every cycle: 1..7, 0 with no bubble
      add(0, 8'hFF, 1, 1, 1, 8'h02, 1);
      add(0, 8'hFF, 1, 1, 1, 8'h04, 2);
      add(0, 8'hFF, 1, 1, 1, 8'h08, 3);
      add(0, 8'hFF, 1, 1, 1, 8'h10, 4);
      add(0, 8'hFF, 1, 1, 1, 8'h20, 5);
      add(0, 8'hFF, 1, 1, 1, 8'h40, 6);
      add(0, 8'hFF, 1, 1, 1, 8'h80, 7);
      add(0, 8'hFF, 1, 1, 1, 8'h01, 0);
      // Release with no requests -> idle (ptr=1)
      add(0, 8'h00, 1, 1, 0, 8'h00, 0);
      // Fixed priority: lowest set bit of 0110_1000 is 3
      add(0, 8'h68, 0, 0, 1, 8'h08, 3);
      // Hold against request change, winner dropped its req
      add(0, 8'h01, 0, 0, 1, 8'h08, 3);
      add(0, 8'h01, 0, 0, 1, 8'h08, 3);
      // Ack -> idx 0 (ptr=4)
      add(0, 8'h01, 0, 1, 1, 8'h01, 0);
      // Ack with no requests -> idle (ptr=1)
      add(0, 8'h00, 0, 1, 0, 8'h00, 0);
      // Ack while idle is ignored
      add(0, 8'h00, 0, 1, 0, 8'h00, 0);
      // Grant idx 5, then ack with req=0000_0011 in rr mode: ptr=6 wraps to 0
      add(0, 8'h20, 0, 0, 1, 8'h20, 5);
      add(0, 8'h03, 1, 1, 1, 8'h01, 0);
      // Same in fixed mode
      add(0, 8'h20, 0, 1, 1, 8'h20, 5);
      add(0, 8'h03, 0, 1, 1, 8'h01, 0);
      // Idx 5 again, then req=1100_0010 rr from ptr=6 -> 6
      add(0, 8'h20, 0, 1, 1, 8'h20, 5);
      add(0, 8'hC2, 1, 1, 1, 8'h40, 6);
      // Grant idx 2, ack with req=0 -> idle (ptr=3), then rr all -> 3
      add(0, 8'h04, 0, 1, 1, 8'h04, 2);
      add(0, 8'h00, 0, 1, 0, 8'h00, 0);
      add(0, 8'hFF, 1, 0, 1, 8'h08, 3);
      // Mode switch does not disturb a held grant
      add(0, 8'hFF, 0, 0, 1, 8'h08, 3);
      // Reset mid-grant drops it; next grant from ptr=0
      add(1, 8'hFF, 1, 0, 0, 8'h00, 0);
      add(0, 8'hFF, 1, 0, 1, 8'h01, 0);
      // Sole requester wins again after its own release
      add(0, 8'h01, 1, 1, 1, 8'h01, 0);
      add(0, 8'h00, 1, 1, 0, 8'h00, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].mode, vecs[i].ack);
         step();
         check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eg, vecs[i].ei, vecs[i].et);
      end

`ifdef ARB_TIMEOUT_EN
      et_exp = 1'b1;
`else
      et_exp = 1'b0;
`endif

      // Timeout: sole requester 2 held without ack
      drive(1'b1, 8'h00, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h04, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("to_hold%0d", k), 1'b1, 8'h04, 3'd2, 1'b0);
      end
      step();
      check("to_pulse_regrant", 1'b1, 8'h04, 3'd2, et_exp);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("to_rehold%0d", k), 1'b1, 8'h04, 3'd2, 1'b0);
      end
      // Forced release rearbitrates round-robin from ptr=3
      drive(1'b0, 8'h0C, 1'b1, 1'b0);
      step();
`ifdef ARB_TIMEOUT_EN
      check("to_rr_next", 1'b1, 8'h08, 3'd3, 1'b1);
`else
      check("to_rr_next", 1'b1, 8'h04, 3'd2, 1'b0);
`endif
      step();
`ifdef ARB_TIMEOUT_EN
      check("to_pulse_end", 1'b1, 8'h08, 3'd3, 1'b0);
`else
      check("to_pulse_end", 1'b1, 8'h04, 3'd2, 1'b0);
`endif
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      step();
      check("to_idle", 1'b0, 8'h00, 3'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Parametrised N-requester arbiter; successor to the fixed 4-input registered priority encoder.
- Adds a run-time selectable fixed-priority / round-robin mode, a grant-hold handshake with downstream ack, and a one-hot plus binary grant output.
- Sits between request sources (DMA channels, bus masters) and a single shared resource.
- All outputs are registered.

Parameters:
- N, 8, number of requesters (>=2).
- IDXW, $clog2(N), width of grant_idx.
- TIMEOUT, 16, grant timeout in cycles (used only with ARB_TIMEOUT_EN; >=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector; bit i = requester i.
- mode  in  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- ack  in  1  downstream consumed current grant; meaningful only while valid=1.
- grant  out  N  one-hot grant; all zeros when valid=0.
- grant_idx  out  IDXW  binary index of granted bit; 0 when valid=0.
- valid  out  1  a grant is currently held.
- timeout  out  1  one-cycle pulse, forced release (always 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset: rst=1 sampled at an edge -> after that edge valid=0, grant=0, grant_idx=0, timeout=0, rr pointer ptr=0, timeout counter=0. Reset overrides req/ack; reset mid-grant drops the grant.
- FSM state IDLE (valid=0):
  - |req=1 at edge -> GRANT; winner registered at that edge (latency 1).
  - Otherwise stay.
  - ack ignored (no pointer change).
- FSM state GRANT (valid=1):
  - Winner held constant while ack=0, regardless of req changes, including the winner dropping its req.
  - ack=1 at edge -> release; ptr <= (grant_idx+1) mod N.
  - On release, if |req=1 at the same edge, the new winner is registered immediately; back-to-back grants keep valid=1 with no bubble.
  - On release with req=0 -> IDLE.
- Winner selection uses req and mode sampled at the decision edge:
  - Fixed: lowest set index wins.
  - Round-robin: first set index searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
  - Released requester may win again if it is the only one requesting.
- ptr advances on every release in both modes.
- Switching mode takes effect at the next decision only; it never changes a held grant.
- Invariants: grant == (1<<grant_idx) when valid=1; grant==0 and grant_idx==0 when valid=0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on every new grant; increments each GRANT cycle with ack=0.
  - When counter==TIMEOUT-1 and ack=0 at an edge, a forced release is performed, identical to an ack release (ptr advance, immediate rearbitration).
  - timeout=1 for the cycle after that edge.
  - The same winner cannot be held for more than TIMEOUT cycles.
- Undefined: no counter logic; timeout tied to 0; grants hold indefinitely until ack.

Test Plan:
- Reset with req=8'hFF, mode=1 held for 2 cycles -> valid=0, grant=8'h00, grant_idx=0 throughout; first grant appears 1 cycle after rst falls, idx=0.
- mode=0, req=8'b0110_1000, ack=0 -> next cycle grant=8'h08, idx=3, valid=1. Then req changes to 8'h01 -> grant stays 8'h08 until ack; after ack, idx=0.
- mode=1, req=8'hFF held, ack=1 every cycle -> idx sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles; valid stays 1 (no bubble).
- Wrap-around: grant idx=5 acked (ptr=6), req=8'b0000_0011, mode=1 -> next grant idx=0. Same case with mode=0 -> idx=0; with req=8'b1100_0010, mode=1 -> idx=6.
- ack=1 while valid=0 with req=0 -> no change. Then ack on grant idx=2 with req=0 -> valid=0, grant=0 next cycle; subsequent req=8'hFF in mode=1 -> idx=3.
- ARB_TIMEOUT_EN, TIMEOUT=4, req=8'h04, ack=0 -> valid=1 idx=2 for 4 cycles, then timeout=1 for 1 cycle. With req still 8'h04 the grant is re-issued (idx=2, counter restarted); with req=8'h0C in mode=1 the new grant is idx=3.
